i2s_voice_sched: RTL and testbench
==================================

Name: i2s_voice_sched

Overview:
Scheduler that sits between the synth voice engines and i2s_tx.
- Once per I2S frame it polls NUM_VOICES voices in order over a req/ack handshake and sums their stereo samples.
- It saturates the sums and left-justifies them.
- It presents the result on left_chan/right_chan at the next frame boundary. Stable double-buffered words are therefore held for the whole serial frame.

Parameters:
DATA_WIDTH, 32, width of left_chan/right_chan, matching the i2s_tx DATA_WIDTH; must be >= SAMPLE_WIDTH.
SAMPLE_WIDTH, 16, signed two's-complement width of each voice sample.
NUM_VOICES, 8, number of voices polled per frame (>= 1).
TIMEOUT, 15, maximum cycles to wait for ack before skipping a voice (>= 1).

Ports:
clk  in  1  system clock; the same clock that drives i2s_tx.
rst  in  1  synchronous reset, active-high.
lrclk  in  1  lrclk output of i2s_tx; same clock domain, no synchroniser.
req  out  1  request for a sample from voice req_voice.
req_voice  out  $clog2(NUM_VOICES) (min 1)  index of the voice being polled.
ack  in  1  voice has driven s_left/s_right valid this cycle.
s_left  in  SAMPLE_WIDTH  signed left sample, sampled only when req&&ack.
s_right  in  SAMPLE_WIDTH  signed right sample, sampled only when req&&ack.
left_chan  out  DATA_WIDTH  to i2s_tx left_chan.
right_chan  out  DATA_WIDTH  to i2s_tx right_chan.
busy  out  1  high while a polling sequence is in progress.
underrun  out  1  one-cycle pulse: frame boundary reached before the mix was complete.
timeout  out  1  one-cycle pulse: the current voice was skipped for no ack.

Behaviour:
Reset values:
- req=0, req_voice=0, left_chan=0, right_chan=0, busy=0, underrun=0, timeout=0.
- Accumulators=0, pend_valid=0, state=IDLE, lrclk_q=1.
- Reset mid-sequence drops req on the next edge; no partial mix is kept.

Frame tick:
- tick = (lrclk==0) && (lrclk_q==1), where lrclk_q is lrclk registered every cycle. This marks the start of the left slot.

Accumulators:
- Width SAMPLE_WIDTH+$clog2(NUM_VOICES)+1, signed.
- Inputs are sign-extended before adding.

States:
- IDLE:
  - On tick with pend_valid=1: left_chan/right_chan <= pending words, pend_valid <= 0.
  - On tick with pend_valid=0: outputs hold. This is silent (no underrun) for the first tick after reset.
  - In both cases: clear accumulators, idx <= 0, go to POLL.
- POLL:
  - req=1, req_voice=idx, busy=1; wait counter increments each cycle.
  - req&&ack: add s_left/s_right, clear the wait counter.
  - Wait counter reaches TIMEOUT with no ack: timeout pulse, voice contributes 0, clear the wait counter.
  - In either case: if idx==NUM_VOICES-1 go to SAT, else idx+1 and stay in POLL. Back-to-back acks give one voice per cycle.
- SAT:
  - Clip each accumulator to [-2^(SAMPLE_WIDTH-1), 2^(SAMPLE_WIDTH-1)-1].
  - Store as {clipped, (DATA_WIDTH-SAMPLE_WIDTH) zeros} into the pending words; pend_valid <= 1.
  - req=0; go to IDLE.

Boundary and priority rules:
- Tick while in POLL or SAT: underrun pulse, outputs and pending words unchanged, sequence restarts at voice 0 with cleared accumulators. Tick beats a simultaneous final ack.
- A second sequence completing while pend_valid=1 overwrites the pending words, so the newest mix wins.
- ack while req=0 is ignored.

Latency:
- Outputs change on the clock edge that ends the tick cycle.
- Minimum sequence length is NUM_VOICES+1 cycles. This must be shorter than the frame period; a longer sequence produces underrun.

Decomposition:
- Package i2s_pkg holds the state encoding (IDLE/POLL/SAT) and an accumulator-width constant function of SAMPLE_WIDTH and NUM_VOICES.
- One sub-module, sat_clip (parameters IN_W, OUT_W): combinational signed saturation. It is instantiated twice, for left and right.

Test Plan:
1. Reset, then first tick with all voices acking immediately: left_chan/right_chan stay 0 and no underrun. At the second tick the outputs take the first mix.
2. 8 voices, s_left=16'h1000 and s_right=16'hF000 each: sum +32768 clips, giving left_chan=32'h7FFF0000; sum -32768 is exact, giving right_chan=32'h80000000.
3. Voices 0..7 give left=1..8 and right=-(1..8): left_chan=32'h00240000 and right_chan=32'hFFDC0000. req_voice steps 0..7, one per cycle.
4. Voice 3 never acks and the others give 16'h0100: timeout pulses once, TIMEOUT cycles after voice 3's req rises. The result is left_chan=32'h07000000.
5. Acks delayed so the sequence spans a tick: underrun pulses for one cycle, the outputs keep their previous frame values, and req_voice returns to 0.
6. Assert rst during POLL at voice 4: req=0 and busy=0 on the next edge. The outputs are 0 until two ticks after reset is released.

Source files
------------

// File: rtl/i2s_voice_sched_pkg.sv
// i2s_pkg: state encoding and accumulator sizing shared by the voice scheduler.
package i2s_pkg;
  typedef enum logic [1:0] {IDLE, POLL, SAT} state_e;
  function automatic int acc_width(int sample_w, int num_voices);
    return sample_w + $clog2(num_voices) + 1;
  endfunction
endpackage

// File: rtl/i2s_voice_sched_sat_clip.sv
// sat_clip: combinational signed saturation from IN_W down to OUT_W bits.
module sat_clip #(
  parameter int IN_W  = 20,
  parameter int OUT_W = 16
) (
  input  logic [IN_W-1:0]  d_i,
  output logic [OUT_W-1:0] q_o
);
  localparam logic [IN_W-1:0] MAX = {{(IN_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic [IN_W-1:0] MIN = ~MAX;
  always_comb q_o = $signed(d_i) > $signed(MAX) ? MAX[OUT_W-1:0] :
                    $signed(d_i) < $signed(MIN) ? MIN[OUT_W-1:0] : d_i[OUT_W-1:0];
endmodule

// File: rtl/i2s_voice_sched.sv
// i2s_voice_sched: polls voices once per I2S frame, mixes and saturates them,
// and double-buffers the result onto left_chan/right_chan at the next frame start.
module i2s_voice_sched
  import i2s_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int SAMPLE_WIDTH = 16,
  parameter int NUM_VOICES   = 8,
  parameter int TIMEOUT      = 15
) (
  input  logic                                                 clk,
  input  logic                                                 rst,
  input  logic                                                 lrclk,
  output logic                                                 req,
  output logic [(NUM_VOICES > 1 ? $clog2(NUM_VOICES) : 1)-1:0] req_voice,
  input  logic                                                 ack,
  input  logic [SAMPLE_WIDTH-1:0]                              s_left,
  input  logic [SAMPLE_WIDTH-1:0]                              s_right,
  output logic [DATA_WIDTH-1:0]                                left_chan,
  output logic [DATA_WIDTH-1:0]                                right_chan,
  output logic                                                 busy,
  output logic                                                 underrun,
  output logic                                                 timeout
);
  localparam int VW = NUM_VOICES > 1 ? $clog2(NUM_VOICES) : 1;
  localparam int AW = acc_width(SAMPLE_WIDTH, NUM_VOICES);
  localparam int CW = $clog2(TIMEOUT + 1);

  state_e                 state_q, state_d;
  logic                   lrclk_q;
  logic [VW-1:0]          idx_q, idx_d;
  logic [CW-1:0]          wait_q, wait_d;
  logic signed [AW-1:0]   acc_l_q, acc_l_d, acc_r_q, acc_r_d;
  logic [DATA_WIDTH-1:0]  pend_l_q, pend_l_d, pend_r_q, pend_r_d;
  logic [DATA_WIDTH-1:0]  left_q, left_d, right_q, right_d;
  logic                   pend_valid_q, pend_valid_d;
  logic                   underrun_q, underrun_d, timeout_q, timeout_d;
  logic [SAMPLE_WIDTH-1:0] clip_l, clip_r;
  logic                   tick, last;

  sat_clip #(.IN_W(AW), .OUT_W(SAMPLE_WIDTH)) u_clip_l (.d_i(acc_l_q), .q_o(clip_l));
  sat_clip #(.IN_W(AW), .OUT_W(SAMPLE_WIDTH)) u_clip_r (.d_i(acc_r_q), .q_o(clip_r));

  assign tick = !lrclk && lrclk_q;
  assign last = idx_q == VW'(NUM_VOICES - 1);

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    wait_d       = wait_q;
    acc_l_d      = acc_l_q;
    acc_r_d      = acc_r_q;
    pend_l_d     = pend_l_q;
    pend_r_d     = pend_r_q;
    pend_valid_d = pend_valid_q;
    left_d       = left_q;
    right_d      = right_q;
    underrun_d   = 1'b0;
    timeout_d    = 1'b0;
    // A frame boundary always restarts polling; only an idle scheduler publishes.
    if (tick) begin
      underrun_d = state_q != IDLE;
      if (state_q == IDLE && pend_valid_q) begin
        left_d       = pend_l_q;
        right_d      = pend_r_q;
        pend_valid_d = 1'b0;
      end
      acc_l_d = '0;
      acc_r_d = '0;
      idx_d   = '0;
      wait_d  = '0;
      state_d = POLL;
    end else if (state_q == POLL) begin
      if (ack || wait_q == CW'(TIMEOUT - 1)) begin
        timeout_d = !ack;
        acc_l_d   = ack ? acc_l_q + AW'(signed'(s_left)) : acc_l_q;
        acc_r_d   = ack ? acc_r_q + AW'(signed'(s_right)) : acc_r_q;
        wait_d    = '0;
        idx_d     = last ? idx_q : idx_q + 1'b1;
        state_d   = last ? SAT : POLL;
      end else begin
        wait_d = wait_q + 1'b1;
      end
    end else if (state_q == SAT) begin
      pend_l_d     = DATA_WIDTH'(clip_l) << (DATA_WIDTH - SAMPLE_WIDTH);
      pend_r_d     = DATA_WIDTH'(clip_r) << (DATA_WIDTH - SAMPLE_WIDTH);
      pend_valid_d = 1'b1;
      state_d      = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      lrclk_q      <= 1'b1;
      idx_q        <= '0;
      wait_q       <= '0;
      acc_l_q      <= '0;
      acc_r_q      <= '0;
      pend_l_q     <= '0;
      pend_r_q     <= '0;
      pend_valid_q <= 1'b0;
      left_q       <= '0;
      right_q      <= '0;
      underrun_q   <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      lrclk_q      <= lrclk;
      idx_q        <= idx_d;
      wait_q       <= wait_d;
      acc_l_q      <= acc_l_d;
      acc_r_q      <= acc_r_d;
      pend_l_q     <= pend_l_d;
      pend_r_q     <= pend_r_d;
      pend_valid_q <= pend_valid_d;
      left_q       <= left_d;
      right_q      <= right_d;
      underrun_q   <= underrun_d;
      timeout_q    <= timeout_d;
    end
  end

  assign req        = state_q == POLL;
  assign req_voice  = idx_q;
  assign busy       = state_q != IDLE;
  assign underrun   = underrun_q;
  assign timeout    = timeout_q;
  assign left_chan  = left_q;
  assign right_chan = right_q;
endmodule

// File: tb/tb_i2s_voice_sched.sv
// tb_i2s_voice_sched: random voice traffic against a frame-level mixing model,
// with frame results scoreboarded and checked by an independent monitor.
module tb_i2s_voice_sched;
  localparam int DW = 32, SW = 16, NV = 8, TO = 15, HALF = 20;
  localparam int MAXS = 2 ** (SW - 1) - 1;
  localparam int NFR = 42, RST_FRAME = 34;

  logic clk = 1'b0, rst, lrclk, ack, req, busy, underrun, timeout;
  logic [2:0] req_voice;
  logic [SW-1:0] s_left, s_right;
  logic [DW-1:0] left_chan, right_chan;

  typedef struct {logic [DW-1:0] l; logic [DW-1:0] r; logic ur;} exp_t;
  exp_t sb[$];
  int errors = 0, checks = 0;

  always #5 clk = ~clk;

  i2s_voice_sched #(.DATA_WIDTH(DW), .SAMPLE_WIDTH(SW), .NUM_VOICES(NV), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .lrclk(lrclk), .req(req), .req_voice(req_voice), .ack(ack),
    .s_left(s_left), .s_right(s_right), .left_chan(left_chan), .right_chan(right_chan),
    .busy(busy), .underrun(underrun), .timeout(timeout)
  );

  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp_v, $time);
    end
  endtask

  function automatic logic [DW-1:0] mixw(input int s);
    int c;
    logic [DW-1:0] w;
    c = s > MAXS ? MAXS : (s < -MAXS - 1 ? -MAXS - 1 : s);
    w = '0;
    w[DW-1 -: SW] = c[SW-1:0];
    return w;
  endfunction

  function automatic int rsamp(input bit big);
    logic [SW-1:0] r;
    r = SW'($urandom);
    return big ? int'($signed(r)) : int'($urandom_range(0, 2000)) - 1000;
  endfunction

  // Per-sequence voice behaviour: ack delay in cycles (>= TO means never) and samples.
  int dly[NV], sl[NV], sr[NV], cum[NV];
  int seq_len, t_start, frame;
  bit live;
  logic [DW-1:0] out_l, out_r;

  task automatic new_config(input int f);
    int mode, acc;
    mode = f <= 4 ? f : (f >= RST_FRAME - 1 ? 6 : 5);
    for (int v = 0; v < NV; v++) begin
      case (mode)
        0: begin dly[v] = 0; sl[v] = rsamp(1); sr[v] = rsamp(1); end
        1: begin dly[v] = 0; sl[v] = 'h1000; sr[v] = -'h1000; end
        2: begin dly[v] = 0; sl[v] = v + 1; sr[v] = -(v + 1); end
        3: begin dly[v] = v == 3 ? 1000 : 0; sl[v] = 'h100; sr[v] = 0; end
        4: begin dly[v] = 5; sl[v] = rsamp(0); sr[v] = rsamp(0); end
        5: begin
          dly[v] = $urandom_range(0, 9) == 0 ? 1000 : int'($urandom_range(0, 5));
          sl[v] = rsamp($urandom_range(0, 1) == 1);
          sr[v] = rsamp($urandom_range(0, 1) == 1);
        end
        default: begin dly[v] = $urandom_range(0, 2); sl[v] = rsamp(1); sr[v] = rsamp(0); end
      endcase
    end
    acc = 0;
    for (int v = 0; v < NV; v++) begin
      acc += dly[v] >= TO ? TO : dly[v] + 1;
      cum[v] = acc;
    end
    seq_len = acc;
  endtask

  // Driver: per cycle, checks the polling handshake against the model, plays the voices,
  // drives lrclk/rst, and at each frame start pushes the expected published words.
  initial begin
    int ph, rst_cnt, k, v_e, j, prev, sum_l, sum_r;
    bit rst_prev, lr_prev, rst_now, lr_now, tick, req_e, busy_e, to_e, ack_p, found, done, rst_done;
    rst = 1'b1; lrclk = 1'b1; ack = 1'b0; s_left = '0; s_right = '0;
    live = 0; out_l = '0; out_r = '0; frame = -1; t_start = 0; seq_len = 0;
    rst_prev = 1; lr_prev = 1; ph = HALF; rst_cnt = 0; rst_done = 0;
    for (int cyc = 0; cyc < 19 + 40 * NFR; cyc++) begin
      @(negedge clk);
      req_e = 0; busy_e = 0; to_e = 0; ack_p = 0; v_e = 0; j = 0;
      if (live) begin
        k = cyc - t_start;
        if (k >= 1 && k <= seq_len) begin
          req_e = 1; busy_e = 1; found = 0;
          for (int v = 0; v < NV; v++)
            if (!found && k <= cum[v]) begin v_e = v; found = 1; end
          prev = v_e == 0 ? 0 : cum[v_e - 1];
          j = k - prev - 1;
          ack_p = dly[v_e] < TO && j == dly[v_e];
        end else if (k == seq_len + 1) busy_e = 1;
        for (int v = 0; v < NV; v++)
          if (dly[v] >= TO && k == cum[v] + 1) to_e = 1;
      end
      chk("req", 64'(req), 64'(req_e));
      chk("busy", 64'(busy), 64'(busy_e));
      chk("timeout", 64'(timeout), 64'(to_e));
      if (req_e) chk("req_voice", 64'(req_voice), 64'(v_e));
      if (frame == RST_FRAME && req_e && v_e == 4 && j == 0 && !rst_done) begin
        rst_cnt = 2; rst_done = 1;
      end
      rst_now = cyc < 3 || rst_cnt > 0;
      if (rst_cnt > 0) rst_cnt--;
      ph = (ph + 1) % (2 * HALF);
      lr_now = ph >= HALF;
      if (ack_p) begin
        ack = 1'b1; s_left = SW'(sl[v_e]); s_right = SW'(sr[v_e]);
      end else begin
        ack = !req_e && $urandom_range(0, 3) == 0;
        s_left = SW'($urandom); s_right = SW'($urandom);
      end
      tick = !lr_now && (rst_prev || lr_prev) && !rst_now;
      if (rst_now) begin
        live = 0; out_l = '0; out_r = '0;
      end else if (tick) begin
        done = live && t_start + seq_len + 1 < cyc;
        if (done) begin
          sum_l = 0; sum_r = 0;
          for (int v = 0; v < NV; v++)
            if (dly[v] < TO) begin sum_l += sl[v]; sum_r += sr[v]; end
          out_l = mixw(sum_l); out_r = mixw(sum_r);
        end
        sb.push_back('{l: out_l, r: out_r, ur: live && !done});
        frame++;
        new_config(frame);
        live = 1; t_start = cyc;
      end
      rst_prev = rst_now; lr_prev = lr_now;
      rst = rst_now; lrclk = lr_now;
    end
    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 64'(sb.size()), 64'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Monitor: tracks frame starts seen on the bus and checks outputs every cycle.
  initial begin
    logic lrq;
    exp_t cur, e;
    logic ur_e;
    lrq = 1'b1;
    cur = '{l: '0, r: '0, ur: 1'b0};
    forever begin
      @(posedge clk);
      #1;
      ur_e = 1'b0;
      if (rst) begin
        cur = '{l: '0, r: '0, ur: 1'b0};
      end else if (!lrclk && lrq) begin
        if (sb.size() == 0) begin
          chk("scoreboard_empty", 64'(1), 64'(0));
        end else begin
          e = sb.pop_front();
          cur = e;
          ur_e = e.ur;
        end
      end
      chk("left_chan", 64'(left_chan), 64'(cur.l));
      chk("right_chan", 64'(right_chan), 64'(cur.r));
      chk("underrun", 64'(underrun), 64'(ur_e));
      lrq = rst ? 1'b1 : lrclk;
    end
  end
endmodule
